// File: rtl/avalon_multi_timer_pkg.sv
// avalon_multi_timer_pkg: register offsets and CONTROL/STATUS bit positions shared by the timer RTL
package avalon_multi_timer_pkg;
  typedef enum logic [2:0] {
    REG_STATUS, REG_CONTROL, REG_PERIOD_LO, REG_PERIOD_HI,
    REG_SNAP_LO, REG_SNAP_HI, REG_PRESCALE, REG_RSVD
  } reg_e;
  localparam int CTRL_ITO = 0;
  localparam int CTRL_CONT = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP = 3;
  localparam int STAT_TO = 0;
  localparam int STAT_RUN = 1;
endpackage

// File: rtl/avalon_multi_timer_channel.sv
// timer_channel: one timer channel (regs, prescaler, down-counter, RUN/TO, irq); in: clk, reset_n, wr, sel, wdata; out: rdata, irq
module timer_channel
  import avalon_multi_timer_pkg::*;
#(
  parameter int CNT_W = 40,
  parameter int PRE_W = 16,
  parameter int RESET_PERIOD = 49999
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr,
  input  logic [2:0]  sel,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);
  logic [CNT_W-1:0] period, counter, snap;
  logic [PRE_W-1:0] prescale, pre_cnt;
  logic [63:0] period64, snap64;
  logic ito, cont, run, to, zero_q, force_reload;
  logic wr_status, wr_ctrl, start, stop, wr_lo, wr_hi, wr_snap, wr_pre, tick, zero;
  assign period64 = 64'(period);
  assign snap64 = 64'(snap);
  assign wr_status = wr && sel == REG_STATUS;
  assign wr_ctrl = wr && sel == REG_CONTROL;
  assign start = wr_ctrl && wdata[CTRL_START];
  assign stop = wr_ctrl && wdata[CTRL_STOP];
  assign wr_lo = wr && sel == REG_PERIOD_LO;
  assign wr_hi = wr && sel == REG_PERIOD_HI && CNT_W > 32;
  assign wr_snap = wr && (sel == REG_SNAP_LO || sel == REG_SNAP_HI);
  assign wr_pre = wr && sel == REG_PRESCALE;
  assign tick = pre_cnt == '0;
  assign zero = counter == '0;
  assign irq = to && ito;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      period <= CNT_W'(RESET_PERIOD);
      counter <= CNT_W'(RESET_PERIOD);
      snap <= '0;
      prescale <= '0;
      pre_cnt <= '0;
      ito <= 1'b0;
      cont <= 1'b0;
      run <= 1'b0;
      to <= 1'b0;
      zero_q <= 1'b0;
      force_reload <= 1'b0;
    end else begin
      if (wr_lo) period <= CNT_W'({period64[63:32], wdata});
      if (wr_hi) period <= CNT_W'({wdata, period64[31:0]});
      if (wr_snap) snap <= counter;
      if (wr_pre) prescale <= PRE_W'(wdata);
      if (wr_ctrl) {cont, ito} <= wdata[CTRL_CONT:CTRL_ITO];
      force_reload <= wr_lo || wr_hi;
      if (start || force_reload) pre_cnt <= prescale;
      else if (run) pre_cnt <= tick ? prescale : pre_cnt - PRE_W'(1);
      if (force_reload) counter <= period;
      else if (run && tick) counter <= zero ? period : counter - CNT_W'(1);
      run <= start || (run && !(stop || force_reload || (zero && !cont)));
      zero_q <= zero;
      to <= !wr_status && (to || (zero && !zero_q));
    end
  always_comb begin
    rdata = '0;
    case (reg_e'(sel))
      REG_STATUS: rdata = {30'd0, run, to};
      REG_CONTROL: rdata = {30'd0, cont, ito};
      REG_PERIOD_LO: rdata = period64[31:0];
      REG_PERIOD_HI: rdata = period64[63:32];
      REG_SNAP_LO: rdata = snap64[31:0];
      REG_SNAP_HI: rdata = snap64[63:32];
      REG_PRESCALE: rdata = 32'(prescale);
      default: rdata = '0;
    endcase
  end
endmodule

// File: rtl/avalon_multi_timer.sv
// avalon_multi_timer: NUM_CH-channel interval timer on Avalon-MM; in: clk, reset_n, address, chipselect, write_n, writedata; out: readdata, irq, irq_vec
module avalon_multi_timer
  import avalon_multi_timer_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CNT_W = 40,
  parameter int PRE_W = 16,
  parameter int RESET_PERIOD = 49999,
  parameter int ADDR_W = $clog2(NUM_CH) + 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq,
  output logic [NUM_CH-1:0] irq_vec
);
  logic [ADDR_W-1:0] ch;
  logic [31:0] rdata [NUM_CH];
  logic [31:0] rd_mux;
  assign ch = address >> 3;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    timer_channel #(
      .CNT_W(CNT_W),
      .PRE_W(PRE_W),
      .RESET_PERIOD(RESET_PERIOD)
    ) u_ch (
      .clk(clk),
      .reset_n(reset_n),
      .wr(chipselect && !write_n && ch == ADDR_W'(i)),
      .sel(address[2:0]),
      .wdata(writedata),
      .rdata(rdata[i]),
      .irq(irq_vec[i])
    );
  end
  always_comb begin
    rd_mux = '0;
    for (int j = 0; j < NUM_CH; j++) rd_mux = ch == ADDR_W'(j) ? rdata[j] : rd_mux;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) readdata <= '0;
    else readdata <= rd_mux;
  assign irq = |irq_vec;
endmodule

// File: tb/tb_avalon_multi_timer.sv
// tb_avalon_multi_timer: self-checking bench with a closed-form timing model of the multi-channel timer
module tb_avalon_multi_timer;
  localparam int NUM_CH = 3;
  localparam int CNT_W = 40;
  localparam int PRE_W = 16;
  localparam int ADDR_W = $clog2(NUM_CH) + 3;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic chipselect = 1'b0;
  logic write_n = 1'b1;
  logic [ADDR_W-1:0] address = '0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic irq;
  logic [NUM_CH-1:0] irq_vec;
  int total = 0;
  int bad = 0;
  avalon_multi_timer #(
    .NUM_CH(NUM_CH),
    .CNT_W(CNT_W),
    .PRE_W(PRE_W),
    .RESET_PERIOD(49999)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .irq(irq),
    .irq_vec(irq_vec)
  );
  always #5 clk = ~clk;
  // counter value t cycles after RUN went high, starting from a fresh reload
  function automatic longint cnt_at(longint p, longint s, longint t);
    return p - ((t % ((p + 1) * (s + 1))) / (s + 1));
  endfunction
  // continuous mode: TO becomes visible one cycle after each counter zero entry
  function automatic bit to_rise(longint p, longint s, longint t);
    return t > 0 && ((t - 1) % ((p + 1) * (s + 1))) == p * (s + 1);
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input int ch, input int r, input logic [31:0] d);
    address = ADDR_W'(ch * 8 + r);
    chipselect = 1'b1;
    write_n = 1'b0;
    writedata = d;
    step();
    chipselect = 1'b0;
    write_n = 1'b1;
  endtask
  task automatic rd(input int ch, input int r, output logic [31:0] d);
    address = ADDR_W'(ch * 8 + r);
    step();
    d = readdata;
  endtask
  // returns in the first cycle with RUN=1, counter=p, pre_cnt=s
  task automatic start(input int ch, input int p, input int s, input logic [31:0] ctrl);
    wr(ch, 0, 0);
    wr(ch, 6, s);
    wr(ch, 2, p);
    wr(ch, 3, 0);
    wr(ch, 1, ctrl);
  endtask
  task automatic test_reset();
    logic [31:0] d;
    reset_n = 1'b0;
    repeat (3) step();
    total++; if (irq !== 1'b0 || irq_vec !== '0 || readdata !== '0) begin bad++; $display("FAIL reset_outputs: irq=%b vec=%b rd=%h, need all 0", irq, irq_vec, readdata); end
    reset_n = 1'b1;
    step();
    rd(0, 2, d); total++; if (d !== 32'd49999) begin bad++; $display("FAIL reset_period_lo: got %0d need 49999", d); end
    rd(0, 3, d); total++; if (d !== 32'd0) begin bad++; $display("FAIL reset_period_hi: got %h need 0", d); end
    rd(0, 0, d); total++; if (d !== 32'd0) begin bad++; $display("FAIL reset_status: got %h need 0", d); end
    rd(1, 1, d); total++; if (d !== 32'd0) begin bad++; $display("FAIL reset_control: got %h need 0", d); end
    rd(1, 6, d); total++; if (d !== 32'd0) begin bad++; $display("FAIL reset_prescale: got %h need 0", d); end
    rd(2, 4, d); total++; if (d !== 32'd0) begin bad++; $display("FAIL reset_snap: got %h need 0", d); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b need 0", irq); end
  endtask
  task automatic test_continuous();
    bit e;
    start(0, 4, 0, 32'h7);
    for (int t = 0; t <= 25; t++) begin
      e = to_rise(4, 0, t);
      total++; if (irq !== e || irq_vec !== NUM_CH'(e)) begin bad++; $display("FAIL cont_irq t=%0d: irq=%b vec=%b need %b", t, irq, irq_vec, e); end
      if (e) wr(0, 0, 0);
      else step();
    end
    wr(0, 1, 32'h8);
  endtask
  task automatic test_oneshot();
    logic [31:0] d;
    bit e;
    start(1, 4, 2, 32'h5);
    for (int t = 0; t <= 30; t++) begin
      e = t >= 4 * 3 + 1;
      total++; if (irq !== e || irq_vec !== (NUM_CH'(e) << 1)) begin bad++; $display("FAIL oneshot_irq t=%0d: irq=%b vec=%b need %b", t, irq, irq_vec, e); end
      step();
    end
    rd(1, 0, d); total++; if (d !== 32'h1) begin bad++; $display("FAIL oneshot_status: got %h need 1", d); end
    wr(1, 4, 0);
    rd(1, 4, d); total++; if (d !== 32'h0) begin bad++; $display("FAIL oneshot_hold0: got %h need 0", d); end
    wr(1, 0, 0);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL oneshot_clear: got %b need 0", irq); end
  endtask
  task automatic test_wide();
    logic [31:0] d;
    int k;
    wr(0, 0, 0);
    wr(0, 6, 0);
    wr(0, 2, 0);
    wr(0, 3, 32'hFFFF_FF01);
    wr(0, 1, 32'h6);
    wr(0, 5, 0);
    rd(0, 5, d); total++; if (d !== 32'h1) begin bad++; $display("FAIL wide_snap_hi0: got %h need 1", d); end
    rd(0, 4, d); total++; if (d !== 32'h0) begin bad++; $display("FAIL wide_snap_lo0: got %h need 0", d); end
    k = $urandom_range(0, 20);
    repeat (k) step();
    wr(0, 4, 0);
    rd(0, 5, d); total++; if (d !== 32'h0) begin bad++; $display("FAIL wide_snap_hi1: got %h need 0", d); end
    rd(0, 4, d); total++; if (d !== 32'(64'h1_0000_0000 - longint'(3 + k))) begin bad++; $display("FAIL wide_snap_lo1: got %h need %h", d, 32'(64'h1_0000_0000 - longint'(3 + k))); end
    rd(0, 3, d); total++; if (d !== 32'h1) begin bad++; $display("FAIL wide_period_hi: got %h need 1", d); end
    wr(0, 1, 32'h8);
  endtask
  task automatic test_same_cycle();
    logic [31:0] d;
    start(0, 3, 0, 32'h7);
    repeat (3) step();
    wr(0, 0, 0);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL same_cycle_irq: got %b need 0", irq); end
    rd(0, 0, d); total++; if (d !== 32'h2) begin bad++; $display("FAIL same_cycle_status: got %h need 2", d); end
    step();
    step();
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL same_cycle_pre: got %b need 0", irq); end
    step();
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL same_cycle_next_to: got %b need 1", irq); end
    wr(0, 1, 32'h8);
    wr(0, 0, 0);
    wr(2, 1, 32'hC);
    rd(2, 0, d); total++; if (d !== 32'h2) begin bad++; $display("FAIL start_stop_run: got %h need 2", d); end
    rd(2, 1, d); total++; if (d !== 32'h0) begin bad++; $display("FAIL start_stop_ctrl: got %h need 0", d); end
    wr(2, 1, 32'h8);
    rd(2, 0, d); total++; if (d !== 32'h0) begin bad++; $display("FAIL stop_run: got %h need 0", d); end
  endtask
  task automatic test_period_write();
    logic [31:0] d;
    start(0, 10, 0, 32'h6);
    repeat (3) step();
    wr(0, 2, 7);
    rd(0, 0, d); total++; if (d !== 32'h2) begin bad++; $display("FAIL pw_run_still: got %h need 2", d); end
    wr(0, 4, 0);
    rd(0, 0, d); total++; if (d !== 32'h0) begin bad++; $display("FAIL pw_run_cleared: got %h need 0", d); end
    rd(0, 4, d); total++; if (d !== 32'd7) begin bad++; $display("FAIL pw_counter: got %0d need 7", d); end
    wr(3, 2, 32'd123);
    rd(3, 2, d); total++; if (d !== 32'h0) begin bad++; $display("FAIL bad_ch_read: got %h need 0", d); end
    rd(0, 2, d); total++; if (d !== 32'd7) begin bad++; $display("FAIL bad_ch_write: got %0d need 7", d); end
    rd(0, 7, d); total++; if (d !== 32'h0) begin bad++; $display("FAIL reserved_read: got %h need 0", d); end
    wr(0, 6, 32'hABCD_0003);
    rd(0, 6, d); total++; if (d !== 32'h3) begin bad++; $display("FAIL prescale_trunc: got %h need 3", d); end
  endtask
  task automatic test_random();
    logic [31:0] d;
    bit e;
    int ch, p, s, ts;
    for (int n = 0; n < 6; n++) begin
      ch = $urandom_range(0, NUM_CH - 1);
      p = $urandom_range(2, 9);
      s = $urandom_range(0, 3);
      start(ch, p, s, 32'h7);
      for (int t = 0; t <= 3 * (p + 1) * (s + 1); t++) begin
        e = to_rise(p, s, t);
        total++; if (irq !== e || irq_vec !== (NUM_CH'(e) << ch)) begin bad++; $display("FAIL rand_irq ch=%0d p=%0d s=%0d t=%0d: irq=%b vec=%b need %b", ch, p, s, t, irq, irq_vec, e); end
        if (e) wr(ch, 0, 0);
        else step();
      end
      wr(ch, 1, 32'h8);
      start(ch, p, s, 32'h6);
      ts = $urandom_range(0, 40);
      repeat (ts) step();
      wr(ch, 4, 0);
      rd(ch, 4, d); total++; if (d !== 32'(cnt_at(p, s, ts))) begin bad++; $display("FAIL rand_snap ch=%0d p=%0d s=%0d t=%0d: got %0d need %0d", ch, p, s, ts, d, cnt_at(p, s, ts)); end
      wr(ch, 1, 32'h8);
    end
  endtask
  task automatic test_async_reset();
    logic [31:0] d;
    start(0, 2, 0, 32'h7);
    repeat (3) step();
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL areset_pre_irq: got %b need 1", irq); end
    #2 reset_n = 1'b0;
    #1;
    total++; if (irq !== 1'b0 || irq_vec !== '0 || readdata !== '0) begin bad++; $display("FAIL areset_immediate: irq=%b vec=%b rd=%h need 0", irq, irq_vec, readdata); end
    step();
    reset_n = 1'b1;
    step();
    rd(0, 2, d); total++; if (d !== 32'd49999) begin bad++; $display("FAIL areset_period: got %0d need 49999", d); end
    rd(0, 0, d); total++; if (d !== 32'h0) begin bad++; $display("FAIL areset_status: got %h need 0", d); end
  endtask
  initial begin
    #1;
    test_reset();
    test_continuous();
    test_oneshot();
    test_wide();
    test_same_cycle();
    test_period_write();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
